core_lsu_bridge: RTL and testbench

Parametrised load/store bus unit between the processor datapath and the single-port AHB master interface (ahb_en / ahb_busy / ahb_rd_vld handshake).
- Adds a posted write buffer of configurable depth.
- Reads may overtake buffered writes unless they hit the same word.
- Adds byte/half/word lane steering, sign extension and misalignment detection.
- Every access runs through this block; the core issues at most one request per cycle.

---
 rtl/core_lsu_bridge.sv | 229 ++++++++++++++++++++++
 tb/tb_core_lsu_bridge.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_lsu_bridge.sv
// Load/store bridge between the core datapath and a single-port AHB-style master:
// posted write buffer, read overtaking with same-word hazard check, lane steering.
module core_lsu_bridge #(
  parameter int ADDR_W     = 32,
  parameter int WBUF_DEPTH = 4,
  parameter int WBUF_EN    = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cpu_en,
  input  logic              i_req_vld,
  output logic              o_req_rdy,
  input  logic              i_req_wr,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_signed,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_vld,
  output logic              o_rsp_err,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_wbuf_empty,
  output logic              o_ahb_en,
  output logic              o_ahb_wr_en,
  output logic [ADDR_W-1:0] o_ahb_addr,
  output logic [31:0]       o_ahb_wr_data,
  output logic [1:0]        o_ahb_data_size,
  input  logic [31:0]       i_ahb_rd_data,
  input  logic              i_ahb_rd_vld,
  input  logic              i_ahb_busy
);

  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_RD_WAIT} state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic [ADDR_W-1:0]   r_wb_addr [WBUF_DEPTH];
  logic [1:0]          r_wb_size [WBUF_DEPTH];
  logic [31:0]         r_wb_data [WBUF_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;

  logic                r_rd_pend;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [1:0]          r_rd_size;
  logic                r_rd_signed;

  logic                r_rsp_vld;
  logic                r_rsp_err;
  logic [31:0]         r_rsp_rdata;

  logic                w_full;
  logic                w_wr_busy;
  logic                w_req_rdy;
  logic                w_acc;
  logic                w_err;
  logic                w_push;
  logic                w_acc_ld;
  logic                w_pop;
  logic                w_rd_done;
  logic                w_haz_pend;
  logic                w_haz_req;
  logic [31:0]         w_wdata_rep;
  logic [31:0]         w_shifted;
  logic [31:0]         w_rd_ext;

  assign w_full    = (r_count == CNT_W'(WBUF_DEPTH));
  assign w_wr_busy = (r_count != '0) || (r_state == S_WR);
  assign w_err     = (i_req_size == 2'b11) ||
                     ((i_req_size == 2'b01) && i_req_addr[0]) ||
                     ((i_req_size == 2'b10) && (i_req_addr[1:0] != 2'b00));

  // Unbuffered mode admits nothing while a write is still outstanding, so the
  // delayed store response can never collide with another response.
  always_comb begin
    w_req_rdy = 1'b0;
    if (i_rst_n && i_cpu_en && !r_rd_pend) begin
      if (WBUF_EN == 0) w_req_rdy = !w_wr_busy && (r_state == S_IDLE);
      else              w_req_rdy = !i_req_wr || !w_full;
    end
  end

  assign w_acc     = i_req_vld && w_req_rdy;
  assign w_push    = w_acc && i_req_wr && !w_err;
  assign w_acc_ld  = w_acc && !i_req_wr && !w_err;
  assign w_pop     = (r_state == S_WR) && !i_ahb_busy;
  assign w_rd_done = (r_state == S_RD_WAIT) && i_ahb_rd_vld;

  always_comb begin
    case (i_req_size)
      2'b00:   w_wdata_rep = {4{i_req_wdata[7:0]}};
      2'b01:   w_wdata_rep = {2{i_req_wdata[15:0]}};
      default: w_wdata_rep = i_req_wdata;
    endcase
  end

  // Word-granular hazard against every live buffer entry, for both the held read and an incoming one.
  always_comb begin
    w_haz_pend = 1'b0;
    w_haz_req  = 1'b0;
    for (int j = 0; j < WBUF_DEPTH; j++) begin
      if ({1'b0, PTR_W'(PTR_W'(j) - r_rd_ptr)} < r_count) begin
        if (r_wb_addr[j][ADDR_W-1:2] == r_rd_addr[ADDR_W-1:2])  w_haz_pend = 1'b1;
        if (r_wb_addr[j][ADDR_W-1:2] == i_req_addr[ADDR_W-1:2]) w_haz_req  = 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_rd_pend && !w_haz_pend)     w_next_state = S_RD;
        else if (w_acc_ld && !w_haz_req)  w_next_state = S_RD;
        else if (r_count != '0)           w_next_state = S_WR;
      end
      S_WR:      if (!i_ahb_busy)   w_next_state = S_IDLE;
      S_RD:      if (!i_ahb_busy)   w_next_state = S_RD_WAIT;
      S_RD_WAIT: if (i_ahb_rd_vld)  w_next_state = S_IDLE;
      default:                      w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    o_ahb_en        = 1'b0;
    o_ahb_wr_en     = 1'b0;
    o_ahb_addr      = '0;
    o_ahb_wr_data   = '0;
    o_ahb_data_size = 2'b00;
    case (r_state)
      S_WR: begin
        o_ahb_en        = 1'b1;
        o_ahb_wr_en     = 1'b1;
        o_ahb_addr      = r_wb_addr[r_rd_ptr];
        o_ahb_wr_data   = r_wb_data[r_rd_ptr];
        o_ahb_data_size = r_wb_size[r_rd_ptr];
      end
      S_RD: begin
        o_ahb_en        = 1'b1;
        o_ahb_addr      = r_rd_addr;
        o_ahb_data_size = r_rd_size;
      end
      default: ;
    endcase
  end

  // Aligned accesses guarantee addr[0]=0 for halves and addr[1:0]=0 for words,
  // so a single byte-offset shift serves every size.
  always_comb begin
    w_shifted = i_ahb_rd_data >> {r_rd_addr[1:0], 3'b000};
    case (r_rd_size)
      2'b00:   w_rd_ext = {{24{r_rd_signed & w_shifted[7]}}, w_shifted[7:0]};
      2'b01:   w_rd_ext = {{16{r_rd_signed & w_shifted[15]}}, w_shifted[15:0]};
      default: w_rd_ext = w_shifted;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_wb_addr[r_wr_ptr] <= i_req_addr;
      r_wb_size[r_wr_ptr] <= i_req_size;
      r_wb_data[r_wr_ptr] <= w_wdata_rep;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_pend   <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_size   <= 2'b00;
      r_rd_signed <= 1'b0;
    end else if (w_acc_ld) begin
      r_rd_pend   <= 1'b1;
      r_rd_addr   <= i_req_addr;
      r_rd_size   <= i_req_size;
      r_rd_signed <= i_req_signed;
    end else if (w_rd_done) begin
      r_rd_pend   <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_vld   <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_vld   <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      if (w_acc && w_err) begin
        r_rsp_vld <= 1'b1;
        r_rsp_err <= 1'b1;
      end else if (w_push && (WBUF_EN != 0)) begin
        r_rsp_vld <= 1'b1;
      end
      if (w_pop && (WBUF_EN == 0)) r_rsp_vld <= 1'b1;
      if (w_rd_done) begin
        r_rsp_vld   <= 1'b1;
        r_rsp_rdata <= w_rd_ext;
      end
    end
  end

  assign o_req_rdy    = w_req_rdy;
  assign o_rsp_vld    = r_rsp_vld;
  assign o_rsp_err    = r_rsp_err;
  assign o_rsp_rdata  = r_rsp_rdata;
  assign o_wbuf_empty = (r_count == '0) && (r_state != S_WR);

endmodule

// File: tb/tb_core_lsu_bridge.sv
// Directed testbench for core_lsu_bridge: store/load paths, buffer full, read
// overtaking and hazard ordering, error responses and reset during a read.
module tb_core_lsu_bridge;

  logic        clk = 1'b0;
  logic        rstN;
  logic        cpuEn;
  logic        reqVld;
  logic        reqRdy;
  logic        reqWr;
  logic [31:0] reqAddr;
  logic [1:0]  reqSize;
  logic        reqSigned;
  logic [31:0] reqWdata;
  logic        rspVld;
  logic        rspErr;
  logic [31:0] rspRdata;
  logic        wbufEmpty;
  logic        ahbEn;
  logic        ahbWrEn;
  logic [31:0] ahbAddr;
  logic [31:0] ahbWrData;
  logic [1:0]  ahbDataSize;
  logic [31:0] ahbRdData;
  logic        ahbRdVld;
  logic        ahbBusy;

  int errors = 0;
  int checks = 0;

  logic [31:0] obsXfer [8];
  logic [31:0] obsData [8];
  int          nObs;
  logic        rspSeen;
  logic [31:0] rspData;
  logic        accSeen;
  logic        accRsp;

  always #5 clk = ~clk;

  core_lsu_bridge #(.ADDR_W(32), .WBUF_DEPTH(4), .WBUF_EN(1)) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_cpu_en(cpuEn),
    .i_req_vld(reqVld), .o_req_rdy(reqRdy), .i_req_wr(reqWr),
    .i_req_addr(reqAddr), .i_req_size(reqSize), .i_req_signed(reqSigned),
    .i_req_wdata(reqWdata), .o_rsp_vld(rspVld), .o_rsp_err(rspErr),
    .o_rsp_rdata(rspRdata), .o_wbuf_empty(wbufEmpty), .o_ahb_en(ahbEn),
    .o_ahb_wr_en(ahbWrEn), .o_ahb_addr(ahbAddr), .o_ahb_wr_data(ahbWrData),
    .o_ahb_data_size(ahbDataSize), .i_ahb_rd_data(ahbRdData),
    .i_ahb_rd_vld(ahbRdVld), .i_ahb_busy(ahbBusy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one request, expects it to be accepted, and returns one cycle later.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                               input logic sgn, input logic [31:0] wdata);
    reqWr = wr; reqAddr = addr; reqSize = size; reqSigned = sgn; reqWdata = wdata;
    reqVld = 1'b1;
    #1;
    checkOutput("reqRdy", {31'b0, reqRdy}, 32'd1);
    step();
    reqVld = 1'b0;
  endtask

  task automatic waitAhb(input string tag);
    int n = 0;
    while (!ahbEn && n < 20) begin
      step();
      n++;
    end
    checkOutput(tag, {31'b0, ahbEn}, 32'd1);
  endtask

  // Read already in RD: step into RD_WAIT, return data, check the response.
  task automatic readReply(input string tag, input logic [31:0] data, input logic [31:0] expRdata);
    step();
    checkOutput({tag, "RdyBlocked"}, {31'b0, reqRdy}, 32'd0);
    ahbRdData = data;
    ahbRdVld  = 1'b1;
    step();
    ahbRdVld  = 1'b0;
    checkOutput({tag, "RspVld"}, {31'b0, rspVld}, 32'd1);
    checkOutput({tag, "Rdata"}, rspRdata, expRdata);
  endtask

  // Records every accepted bus transfer, answers reads with rdVal and
  // finishes an outstanding request left on the request port.
  task automatic runBus(input int nXfers, input logic [31:0] rdVal);
    int   cyc = 0;
    logic rdNext = 1'b0;
    logic rdDriven = 1'b0;
    logic accNext = 1'b0;
    nObs = 0; rspSeen = 1'b0; rspData = '0; accSeen = 1'b0; accRsp = 1'b0;
    while ((nObs < nXfers || rdNext || rdDriven || reqVld || accNext) && cyc < 200) begin
      if (rdDriven) begin
        ahbRdVld = 1'b0; rdDriven = 1'b0; rspSeen = rspVld; rspData = rspRdata;
      end
      if (rdNext) begin
        ahbRdData = rdVal; ahbRdVld = 1'b1; rdDriven = 1'b1; rdNext = 1'b0;
      end
      if (accNext) begin
        reqVld = 1'b0; accNext = 1'b0; accSeen = 1'b1; accRsp = rspVld;
      end else if (reqVld && reqRdy) begin
        accNext = 1'b1;
      end
      if (ahbEn && !ahbBusy && nObs < 8) begin
        obsXfer[nObs] = {ahbWrEn, ahbAddr[30:0]};
        obsData[nObs] = ahbWrData;
        nObs++;
        if (!ahbWrEn) rdNext = 1'b1;
      end
      step();
      cyc++;
    end
    checkOutput("busXferCount", 32'(nObs), 32'(nXfers));
  endtask

  initial begin
    logic [31:0] expX [5];
    int          n;
    rstN = 1'b0; cpuEn = 1'b1; reqVld = 1'b0; reqWr = 1'b0; reqAddr = '0;
    reqSize = 2'b00; reqSigned = 1'b0; reqWdata = '0; ahbRdData = '0;
    ahbRdVld = 1'b0; ahbBusy = 1'b0;
    repeat (3) step();
    checkOutput("rstRspVld", {31'b0, rspVld}, 32'd0);
    checkOutput("rstAhbEn", {31'b0, ahbEn}, 32'd0);
    checkOutput("rstWbufEmpty", {31'b0, wbufEmpty}, 32'd1);
    checkOutput("rstReqRdy", {31'b0, reqRdy}, 32'd0);
    rstN = 1'b1;
    step();

    $display("[TB] word store");
    applyStimulus(1'b1, 32'h100, 2'b10, 1'b0, 32'hDEADBEEF);
    checkOutput("st1RspVld", {31'b0, rspVld}, 32'd1);
    checkOutput("st1RspErr", {31'b0, rspErr}, 32'd0);
    checkOutput("st1WbufBusy", {31'b0, wbufEmpty}, 32'd0);
    waitAhb("st1AhbEn");
    checkOutput("st1WrEn", {31'b0, ahbWrEn}, 32'd1);
    checkOutput("st1Addr", ahbAddr, 32'h100);
    checkOutput("st1Size", {30'b0, ahbDataSize}, 32'd2);
    checkOutput("st1Data", ahbWrData, 32'hDEADBEEF);
    step();
    checkOutput("st1Idle", {31'b0, ahbEn}, 32'd0);
    checkOutput("st1WbufEmpty", {31'b0, wbufEmpty}, 32'd1);

    $display("[TB] byte store and byte loads");
    applyStimulus(1'b1, 32'h203, 2'b00, 1'b0, 32'h000000A5);
    waitAhb("stbAhbEn");
    checkOutput("stbData", ahbWrData, 32'hA5A5A5A5);
    checkOutput("stbSize", {30'b0, ahbDataSize}, 32'd0);
    checkOutput("stbAddr", ahbAddr, 32'h203);
    step();
    applyStimulus(1'b0, 32'h203, 2'b00, 1'b1, 32'h0);
    checkOutput("ldsAhbEn", {31'b0, ahbEn}, 32'd1);
    checkOutput("ldsWrEn", {31'b0, ahbWrEn}, 32'd0);
    checkOutput("ldsAddr", ahbAddr, 32'h203);
    checkOutput("ldsSize", {30'b0, ahbDataSize}, 32'd0);
    readReply("lds", 32'h80000000, 32'hFFFFFF80);
    applyStimulus(1'b0, 32'h203, 2'b00, 1'b0, 32'h0);
    readReply("ldu", 32'h80000000, 32'h00000080);

    $display("[TB] buffer full");
    ahbBusy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h40 + 32'(4 * i), 2'b10, 1'b0, 32'h11111111 * (i + 1));
      checkOutput("fillRsp", {31'b0, rspVld}, 32'd1);
    end
    reqWr = 1'b1; reqAddr = 32'h50; reqSize = 2'b10; reqWdata = 32'h55555555; reqVld = 1'b1;
    #1;
    checkOutput("fullRdy", {31'b0, reqRdy}, 32'd0);
    checkOutput("heldAddr", ahbAddr, 32'h40);
    step();
    checkOutput("fullRdy2", {31'b0, reqRdy}, 32'd0);
    checkOutput("heldAddr2", ahbAddr, 32'h40);
    checkOutput("heldData2", ahbWrData, 32'h11111111);
    ahbBusy = 1'b0;
    runBus(5, 32'h0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("fifoAddr", obsXfer[i], 32'h80000040 + 32'(4 * i));
      checkOutput("fifoData", obsData[i], 32'h11111111 * (i + 1));
    end
    checkOutput("fifthAcc", {31'b0, accSeen}, 32'd1);
    checkOutput("fifthRsp", {31'b0, accRsp}, 32'd1);

    $display("[TB] read overtakes buffered write");
    ahbBusy = 1'b1;
    applyStimulus(1'b1, 32'h10, 2'b10, 1'b0, 32'h10101010);
    applyStimulus(1'b1, 32'h20, 2'b10, 1'b0, 32'h20202020);
    applyStimulus(1'b0, 32'h30, 2'b10, 1'b0, 32'h0);
    checkOutput("ovtHeadAddr", ahbAddr, 32'h10);
    ahbBusy = 1'b0;
    runBus(3, 32'h12345678);
    // The head write was already presented on the bus, so it cannot be withdrawn.
    expX[0] = 32'h80000010; expX[1] = 32'h00000030; expX[2] = 32'h80000020;
    for (int i = 0; i < 3; i++) checkOutput("ovtOrder", obsXfer[i], expX[i]);
    checkOutput("ovtRspVld", {31'b0, rspSeen}, 32'd1);
    checkOutput("ovtRdata", rspData, 32'h12345678);

    $display("[TB] same-word read waits for write");
    ahbBusy = 1'b1;
    applyStimulus(1'b1, 32'h10, 2'b10, 1'b0, 32'h10101010);
    applyStimulus(1'b1, 32'h20, 2'b10, 1'b0, 32'h20202020);
    applyStimulus(1'b0, 32'h22, 2'b01, 1'b0, 32'h0);
    ahbBusy = 1'b0;
    runBus(3, 32'hBEEF0000);
    expX[0] = 32'h80000010; expX[1] = 32'h80000020; expX[2] = 32'h00000022;
    for (int i = 0; i < 3; i++) checkOutput("hazOrder", obsXfer[i], expX[i]);
    checkOutput("hazRspVld", {31'b0, rspSeen}, 32'd1);
    checkOutput("hazRdata", rspData, 32'h0000BEEF);

    $display("[TB] error responses");
    applyStimulus(1'b0, 32'h101, 2'b01, 1'b0, 32'h0);
    checkOutput("errHalfVld", {31'b0, rspVld}, 32'd1);
    checkOutput("errHalfErr", {31'b0, rspErr}, 32'd1);
    checkOutput("errHalfRdata", rspRdata, 32'h0);
    checkOutput("errHalfNoBus", {31'b0, ahbEn}, 32'd0);
    step();
    checkOutput("errHalfNoBus2", {31'b0, ahbEn}, 32'd0);
    applyStimulus(1'b1, 32'h104, 2'b11, 1'b0, 32'hFFFFFFFF);
    checkOutput("errRsvErr", {31'b0, rspErr}, 32'd1);
    checkOutput("errRsvEmpty", {31'b0, wbufEmpty}, 32'd1);
    step();
    checkOutput("errRsvNoBus", {31'b0, ahbEn}, 32'd0);

    $display("[TB] reset during read");
    ahbBusy = 1'b1;
    applyStimulus(1'b1, 32'h60, 2'b10, 1'b0, 32'h60606060);
    applyStimulus(1'b1, 32'h64, 2'b10, 1'b0, 32'h64646464);
    applyStimulus(1'b1, 32'h68, 2'b10, 1'b0, 32'h68686868);
    applyStimulus(1'b0, 32'h80, 2'b10, 1'b0, 32'h0);
    ahbBusy = 1'b0;
    n = 0;
    while (!(ahbEn && !ahbWrEn) && n < 20) begin
      step();
      n++;
    end
    checkOutput("rstRdIssued", {31'b0, ahbEn & ~ahbWrEn}, 32'd1);
    step();
    checkOutput("rstPreEmpty", {31'b0, wbufEmpty}, 32'd0);
    checkOutput("rstPreAhbEn", {31'b0, ahbEn}, 32'd0);
    #1 rstN = 1'b0;
    #1;
    checkOutput("rstMidAhbEn", {31'b0, ahbEn}, 32'd0);
    checkOutput("rstMidRsp", {31'b0, rspVld}, 32'd0);
    checkOutput("rstMidEmpty", {31'b0, wbufEmpty}, 32'd1);
    checkOutput("rstMidRdy", {31'b0, reqRdy}, 32'd0);
    step();
    step();
    rstN = 1'b1;
    step();
    ahbRdData = 32'hFFFFFFFF;
    ahbRdVld  = 1'b1;
    step();
    ahbRdVld  = 1'b0;
    checkOutput("rstStaleRsp", {31'b0, rspVld}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("rstNoReplay", {31'b0, ahbEn}, 32'd0);
    end
    checkOutput("rstPostEmpty", {31'b0, wbufEmpty}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
